// File: rtl/dpram_rdr.sv
// Sequential block reader for the read-only X port of the register-file RAM.
// Walks len_i consecutive entries from base_i and streams them over stb/ack.
module dpram_rdr #(
    parameter int AW = 5,
    parameter int DW = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ena_i,
    input  logic          start_i,
    input  logic [AW-1:0] base_i,
    input  logic [AW:0]   len_i,
    output logic [AW-1:0] xadr_o,
    input  logic [DW-1:0] xdat_i,
    output logic [DW-1:0] dat_o,
    output logic          stb_o,
    input  logic          ack_i,
    output logic          busy_o,
    output logic          done_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t        state;
    logic [AW-1:0] ptr;
    logic [AW:0]   rem;
    logic          load;
    logic          pending;

    // A new word may enter the output register when it is empty or being drained this edge.
    assign load    = (state == RUN) && (rem != '0) && (!stb_o || ack_i);
    assign pending = stb_o && !ack_i;
    assign xadr_o  = ptr;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            ptr    <= '0;
            rem    <= '0;
            dat_o  <= '0;
            stb_o  <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else if (ena_i) begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        ptr    <= base_i;
                        rem    <= len_i;
                        busy_o <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (load) begin
                        dat_o <= xdat_i;
                        stb_o <= 1'b1;
                        ptr   <= ptr + 1'b1;
                        rem   <= rem - 1'b1;
                    end else if (ack_i && stb_o) begin
                        stb_o <= 1'b0;
                    end
                    // Finish only once the last word has left the output register.
                    if (rem == '0 && !pending) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= FIN;
                    end
                end
                FIN: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dpram_rdr.sv
// Scoreboard bench for dpram_rdr: a RAM model feeds xdat, expected words are
// queued at each start and popped on every stb/ack handshake.
module tb_dpram_rdr;

    localparam int AW = 5;
    localparam int DW = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic [AW-1:0] xadr;
    logic [DW-1:0] xdat;
    logic [DW-1:0] dat;
    logic          stb;
    logic          ack;
    logic          busy;
    logic          done;

    logic [DW-1:0] ram [0:DEPTH-1];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] mon_exp;
    int            tests = 0;
    int            fails = 0;
    int            accepted = 0;

    dpram_rdr #(.AW(AW), .DW(DW)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .ena_i   (ena),
        .start_i (start),
        .base_i  (base),
        .len_i   (len),
        .xadr_o  (xadr),
        .xdat_i  (xdat),
        .dat_o   (dat),
        .stb_o   (stb),
        .ack_i   (ack),
        .busy_o  (busy),
        .done_o  (done)
    );

    assign xdat = ram[xadr];

    always #5 clk = ~clk;

    // Handshake monitor: a word is consumed on the coming edge when stb & ack & ena.
    always @(negedge clk) begin
        if (!rst && ena && stb && ack) begin
            tests++;
            accepted++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL stream_extra: got dat=%0d, required no word", dat);
            end else begin
                mon_exp = exp_q.pop_front();
                if (dat !== mon_exp) begin
                    fails++;
                    $display("FAIL stream_data: got dat=%0d, required %0d", dat, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int b, input int l);
        start = 1'b1;
        base  = AW'(b);
        len   = (AW+1)'(l);
        for (int i = 0; i < l; i++) exp_q.push_back(ram[(b + i) % DEPTH]);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input bit rand_ack);
        int n = 0;
        while (done !== 1'b1 && n < 400) begin
            if (rand_ack) ack = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        ack = 1'b1;
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL done_timeout: got done=%b after %0d cycles, required 1", done, n);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_at_done: got busy=%b, required 0", busy);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1; ack = 1'b1;
        start = 1'b1; base = AW'(9); len = (AW+1)'(3);
        tick();
        tick();
        tests++;
        if ({stb, busy, done, xadr, dat} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got stb=%b busy=%b done=%b xadr=%0d dat=%0d, required all 0",
                     stb, busy, done, xadr, dat);
        end
        for (int i = 0; i < 3; i++) exp_q.push_back(ram[9 + i]);
        rst = 1'b0;
        tick();
        start = 1'b0;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_first_start: got busy=%b, required 1", busy);
        end
        wait_done(1'b0);
    endtask

    task automatic test_full_rate();
        int a0 = accepted;
        do_start(4, 6);
        for (int k = 1; k <= 8; k++) begin
            tick();
            tests++;
            if (stb !== (k <= 6) || done !== (k == 7)) begin
                fails++;
                $display("FAIL full_rate_c%0d: got stb=%b done=%b, required stb=%b done=%b",
                         k, stb, done, k <= 6, k == 7);
            end
        end
        tests++;
        if (busy !== 1'b0 || accepted - a0 != 6 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL full_rate_end: got busy=%b words=%0d left=%0d, required 0/6/0",
                     busy, accepted - a0, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        ram[30] = 2'd2; ram[31] = 2'd3; ram[0] = 2'd1; ram[1] = 2'd0;
        do_start(30, 4);
        wait_done(1'b0);
        tests++;
        if (xadr !== AW'(2) || exp_q.size() != 0) begin
            fails++;
            $display("FAIL wrap_end: got xadr=%0d left=%0d, required 2/0", xadr, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int            a0 = accepted;
        logic [DW-1:0] held = ram[1];
        do_start(0, 3);
        tick();
        tick();
        ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (stb !== 1'b1 || dat !== held || xadr !== AW'(2)) begin
                fails++;
                $display("FAIL backpressure_hold%0d: got stb=%b dat=%0d xadr=%0d, required 1/%0d/2",
                         k, stb, dat, xadr, held);
            end
        end
        ack = 1'b1;
        wait_done(1'b0);
        tests++;
        if (accepted - a0 != 3 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL backpressure_count: got words=%0d left=%0d, required 3/0",
                     accepted - a0, exp_q.size());
        end
    endtask

    task automatic test_len_zero();
        do_start(7, 0);
        tests++;
        if (done !== 1'b0 || stb !== 1'b0) begin
            fails++;
            $display("FAIL len0_c0: got done=%b stb=%b, required 0/0", done, stb);
        end
        tick();
        tests++;
        if (done !== 1'b1 || stb !== 1'b0) begin
            fails++;
            $display("FAIL len0_c1: got done=%b stb=%b, required 1/0", done, stb);
        end
        tick();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL len0_c2: got done=%b busy=%b, required 0/0", done, busy);
        end
    endtask

    task automatic test_len_full();
        int a0 = accepted;
        do_start(5, DEPTH);
        wait_done(1'b1);
        tests++;
        if (accepted - a0 != DEPTH || exp_q.size() != 0 || xadr !== AW'(5)) begin
            fails++;
            $display("FAIL len32_count: got words=%0d left=%0d xadr=%0d, required 32/0/5",
                     accepted - a0, exp_q.size(), xadr);
        end
    endtask

    task automatic test_restart_busy();
        int a0 = accepted;
        do_start(10, 4);
        start = 1'b1; base = AW'(20); len = (AW+1)'(2);
        tick();
        tick();
        start = 1'b0;
        wait_done(1'b0);
        tests++;
        if (accepted - a0 != 4 || exp_q.size() != 0 || xadr !== AW'(14)) begin
            fails++;
            $display("FAIL restart_ignored: got words=%0d left=%0d xadr=%0d, required 4/0/14",
                     accepted - a0, exp_q.size(), xadr);
        end
    endtask

    task automatic test_ena_hold();
        int            a0 = accepted;
        logic [DW-1:0] held = ram[1];
        do_start(0, 6);
        tick();
        tick();
        ena = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (stb !== 1'b1 || dat !== held || xadr !== AW'(2) || busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL ena_hold%0d: got stb=%b dat=%0d xadr=%0d busy=%b done=%b, required 1/%0d/2/1/0",
                         k, stb, dat, xadr, busy, done, held);
            end
        end
        ena = 1'b1;
        wait_done(1'b0);
        tests++;
        if (accepted - a0 != 6 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL ena_resume: got words=%0d left=%0d, required 6/0", accepted - a0, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        do_start(3, 8);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        tests++;
        if (stb !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || xadr !== '0) begin
            fails++;
            $display("FAIL reset_mid: got stb=%b busy=%b done=%b xadr=%0d, required 0/0/0/0",
                     stb, busy, done, xadr);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done !== 1'b0 || stb !== 1'b0) seen = 1'b1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL reset_mid_quiet: got activity after abort=1, required 0");
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i & 3);
        test_reset();
        test_full_rate();
        test_wrap();
        test_backpressure();
        test_len_zero();
        test_len_full();
        test_restart_busy();
        test_ena_hold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dpram_rdr.md
Name: dpram_rdr

Overview:
- Sequential read engine for the read-only X port of the shared register-file RAM.
- On a start command it walks a block of consecutive RAM entries and streams each word out over a registered valid/ready (stb/ack) interface.
- The block drives the RAM's X address and consumes its asynchronous read data.
- It sits between the RAM X port and downstream consumers such as a debug dump path or a context save unit.

Parameters:
- AW, 5, RAM address width; RAM depth = 1<<AW entries.
- DW, 2, RAM data width; equals the streamed word width.

Ports:
- clk_i  input  1  system clock; all state changes on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- ena_i  input  1  global clock enable; when low, all state holds.
- start_i  input  1  command strobe; sampled only in IDLE with ena_i high.
- base_i  input  AW  first RAM address; captured on an accepted start.
- len_i  input  AW+1  number of words to read, 0 to 1<<AW; captured on an accepted start.
- xadr_o  output  AW  address to the RAM X port; direct from the pointer register.
- xdat_i  input  DW  RAM X-port read data; combinational from xadr_o, valid in the same cycle.
- dat_o  output  DW  streamed data word, registered.
- stb_o  output  1  dat_o valid, registered.
- ack_i  input  1  consumer accepts dat_o in cycles where stb_o & ack_i.
- busy_o  output  1  high from the cycle after an accepted start until done.
- done_o  output  1  single-cycle pulse at completion.

Behaviour:
- Reset (rst_i=1 at a clock edge, overrides ena_i):
  - State returns to IDLE.
  - xadr_o, dat_o, stb_o, busy_o and done_o are all 0.
  - The remaining count is 0.
  - Reset mid-transfer aborts immediately; no done pulse is produced and any pending stb_o is dropped.
- ena_i=0: pointer, count, state, dat_o, stb_o and done_o hold their values. A done pulse stays asserted until the next enabled edge. start_i and ack_i are ignored.
- States: IDLE, RUN, FIN.
- IDLE:
  - start_i=1 loads ptr=base_i and rem=len_i, sets busy_o=1 and moves to RUN.
  - start_i in any other state is ignored.
- RUN:
  - load = (rem != 0) & (~stb_o | ack_i).
  - On load: dat_o <= xdat_i (the RAM word at the current ptr), stb_o <= 1, ptr <= ptr+1 modulo 1<<AW (wraps from 2^AW-1 to 0), rem <= rem-1.
  - If ack_i & stb_o and no load occurs: stb_o <= 0.
  - Move to FIN when rem==0 and no word is pending. A word is pending when stb_o & ~ack_i.
- FIN: done_o=1 for exactly one cycle, busy_o <= 0, then IDLE. done_o is 0 in all other cycles.
- len_i=0: IDLE -> RUN -> FIN with no stb_o, giving a done pulse 2 cycles after start.
- Throughput: one word per cycle while ack_i is held high.
- Latency: the first stb_o is asserted 2 cycles after the start edge (start edge -> RUN; next edge loads).
- Backpressure: with stb_o=1 and ack_i=0, dat_o and stb_o hold, and ptr and rem do not advance. There is no data loss and no duplication.
- len_i=1<<AW reads every entry exactly once, starting at base_i and wrapping.
- Coherency: xdat_i is sampled at the loading edge. A port-A write to the same address on that edge is not visible; the old value is streamed. Writes to addresses not yet loaded are visible.
- Arithmetic: ptr increments modulo 2^AW; rem is AW+1 bits wide and never underflows.

Test Plan:
- Reset sequence: hold rst_i 2 cycles, with start_i held high during reset -> all outputs 0 and state IDLE; start is not accepted until the first cycle after reset.
- Full-rate read, AW=5, DW=2: RAM[i]=i&3, base=4, len=6, ack_i=1 -> stb_o high for 6 consecutive cycles with dat_o=0,1,2,3,0,1; done_o one pulse in the cycle after the last stb; busy_o falls with done.
- Wrap: base=30, len=4, RAM[30]=2, RAM[31]=3, RAM[0]=1, RAM[1]=0 -> dat_o sequence 2,3,1,0; final xadr_o=2.
- Backpressure: len=3, ack_i low for 3 cycles on the second word -> dat_o holds the second word and the third word is not loaded; total accepted words = 3, in order, none duplicated.
- Edge cases:
  - len=0 -> no stb_o, done_o pulse 2 cycles after start.
  - len=32 -> exactly 32 words accepted.
  - Second start_i while busy -> ignored; the original transfer completes unchanged.
- ena_i low for 4 cycles mid-transfer, and rst_i mid-transfer -> with ena_i low, outputs frozen and the stream resumes intact; with rst_i, stb_o, busy_o and done_o are 0 the next cycle and no done pulse appears.
